dds_phase_accum: RTL and testbench
==================================

// Module: dds_phase_accum
// PURPOSE
//  Phase accumulator front end of the DDS chain. Integrates a frequency tuning word (FTW)
//  each clock and emits the truncated, offset phase word that drives the sine LUT stage
//  (14-bit phase input, top 2 bits = quadrant). Supports handshaked FTW loads and a linear
//  frequency sweep (chirp).
// PARAMETERS
//  ACC_W    24  accumulator width (bits); frequency resolution = f_clk / 2^ACC_W
//  PHASE_W  14  output phase width; must match the sine stage input; PHASE_W < ACC_W
//  CNT_W    16  sweep length counter width
// PORTS
//  clk          in   1        system clock; all state updates on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  en           in   1        run enable; 0 forces IDLE
//  ftw_in       in   ACC_W    tuning word to load
//  ftw_valid    in   1        ftw_in valid
//  ftw_ready    out  1        FTW load accepted when ftw_valid & ftw_ready at clk edge
//  phase_off    in   PHASE_W  static phase offset added after truncation
//  sweep_step   in   ACC_W    per-cycle FTW increment, two's complement
//  sweep_len    in   CNT_W    number of sweep increments
//  sweep_start  in   1        sampled pulse; starts sweep
//  phase        out  PHASE_W  registered phase word to sine stage
//  phase_valid  out  1        phase is live (RUN or SWEEP)
//  wrap         out  1        1-cycle pulse on accumulator carry-out
//  busy         out  1        high while in SWEEP
// BEHAVIOUR
//  Reset (async, rst_n=0): acc=0, ftw=0, cnt=0, state=IDLE, phase=0, phase_valid=0,
//    wrap=0, busy=0. ftw_ready=1 (combinational, state-derived).
//  States: IDLE -> RUN when en=1. RUN -> SWEEP on sweep_start & sweep_len!=0.
//    SWEEP -> RUN when cnt reaches 0. Any state -> IDLE when en=0 (highest priority).
//  IDLE: acc and phase held, phase_valid=0, wrap=0. FTW loads accepted. sweep_start ignored.
//  RUN/SWEEP: acc <= acc + ftw mod 2^ACC_W. wrap=1 the cycle after the carry-out.
//    phase <= acc[ACC_W-1 -: PHASE_W] + phase_off mod 2^PHASE_W; wraps silently.
//  Latency: FTW accepted at edge k -> used in the acc update at edge k+1 -> visible on
//    phase after edge k+2.
//  ftw_ready = (state != SWEEP). sweep_len=0 -> sweep_start ignored.
//  Same cycle, FTW load and sweep_start in RUN: load and start both happen. The sweep
//    begins from the newly loaded FTW.
//  SWEEP entry: cnt <= sweep_len. Each SWEEP cycle: ftw <= ftw + sweep_step (wraps mod
//    2^ACC_W), cnt <= cnt-1. Exit after exactly sweep_len increments; ftw keeps final value.
//  en=0 mid-sweep: abort to IDLE next edge; ftw keeps its current value; cnt cleared;
//    busy=0. sweep_step/sweep_len are sampled only at sweep start.
// CONFIGURATION
//  DDS_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on
//    reset; never zero) advances each RUN/SWEEP cycle. Its low (ACC_W-PHASE_W) bits are
//    added to acc before truncation. Requires ACC_W-PHASE_W <= 16.
//  DDS_DITHER_EN undefined: plain truncation; no LFSR logic.
// STRUCTURE
//  Shared package dds_pkg:
//    - state encoding (IDLE=2'd0, RUN=2'd1, SWEEP=2'd2)
//    - defaults for ACC_W/PHASE_W
//    - LFSR seed and taps constants
//  Sub-module dds_lfsr (enable, 16-bit state out) is instantiated only under DDS_DITHER_EN.
// TESTING (ACC_W=24, PHASE_W=14, dither off unless noted)
//  1 Reset: rst_n=0 mid-run, no clock -> phase=0, phase_valid=0, busy=0, ftw_ready=1 at once.
//  2 Load ftw=24'h040000, en=1 -> phase 0x000,0x100,0x200,... step 0x100; wrap every 64 cycles.
//  3 Same as 2 with phase_off=14'h3F80 -> first values 0x3F80, 0x0080 (14-bit wrap).
//  4 ftw=24'h001000, step=24'h000010, len=4, sweep_start -> busy 4 cycles, ftw_ready=0
//    during sweep, final ftw=24'h001040. ftw_valid held during sweep is not accepted.
//  5 en=0 after 2 sweep cycles -> IDLE next edge, busy=0, phase_valid=0, phase frozen.
//    Re-enable -> RUN with ftw=24'h001020.
//  6 DDS_DITHER_EN, ftw=0 -> phase stays constant (dither < 1 LSB), LFSR never 0 over 2^16 cycles.

Source files
------------

// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Shared definitions for the DDS phase accumulator slice:
//               FSM state encoding, default widths and dither LFSR constants.
// Revision    : 1.0  initial release
// ============================================================================
package dds_pkg;

  // Accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } dds_state_e;

  // Default widths
  localparam int DDS_ACC_W   = 24;
  localparam int DDS_PHASE_W = 14;
  localparam int DDS_CNT_W   = 16;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : dds_lfsr
// Description : 16-bit Fibonacci LFSR used as phase dither source. Seeded
//               with a non-zero value so it never locks up at zero.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset (loads seed)
//               en     - advance one step this cycle
//               state  - current LFSR state
// Revision    : 1.0  initial release
// ============================================================================
module dds_lfsr
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/dds_phase_accum.sv
`default_nettype none
// ============================================================================
// Module      : dds_phase_accum
// Description : DDS phase accumulator. Integrates the frequency tuning word
//               every live cycle and emits the truncated, offset phase word
//               for the sine LUT. Supports handshaked FTW loads and a linear
//               FTW sweep (chirp).
// Config      : DDS_DITHER_EN - when defined, an LFSR adds sub-LSB dither to
//               the accumulator before truncation.
// Ports       : clk, rst_n            - clock, async active-low reset
//               en                    - run enable (0 forces IDLE)
//               ftw_in/valid/ready    - tuning word load handshake
//               phase_off             - offset added after truncation
//               sweep_step/len/start  - sweep increment, count and start
//               phase/phase_valid     - registered phase word and live flag
//               wrap                  - 1-cycle accumulator carry pulse
//               busy                  - sweep in progress
// Revision    : 1.0  initial release
// ============================================================================
module dds_phase_accum
  import dds_pkg::*;
#(
  parameter int ACC_W   = DDS_ACC_W,
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int CNT_W   = DDS_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [CNT_W-1:0]   sweep_len,
  input  logic               sweep_start,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic               busy
);

  dds_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   ftw_q, ftw_d;
  logic [ACC_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;

  logic               live;
  logic               ftw_load;
  logic [ACC_W:0]     acc_sum;
  logic [ACC_W-1:0]   acc_trunc_src;

  // Accumulator only advances in RUN/SWEEP with enable still asserted;
  // the edge that drops en freezes everything on the way to IDLE.
  assign live     = en && (state_q != ST_IDLE);
  assign ftw_load = ftw_valid && ftw_ready;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, ftw_q};

`ifdef DDS_DITHER_EN
  localparam int          DITH_W    = ACC_W - PHASE_W;
  localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

  logic [15:0] lfsr_state;

  dds_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (live),
    .state (lfsr_state)
  );

  // Dither only touches the bits discarded by truncation
  assign acc_trunc_src = acc_q + ACC_W'(lfsr_state & DITH_MASK);
`else
  assign acc_trunc_src = acc_q;
`endif

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    ftw_d         = ftw_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;

    // ftw_ready is low in SWEEP, so a load never collides with a sweep step
    if (ftw_load) begin
      ftw_d = ftw_in;
    end

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (sweep_start && (sweep_len != '0)) begin
            state_d = ST_SWEEP;
            cnt_d   = sweep_len;
            step_d  = sweep_step;
          end
        end
        ST_SWEEP: begin
          ftw_d = ftw_q + step_q;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (live) begin
      acc_d         = acc_sum[ACC_W-1:0];
      wrap_d        = acc_sum[ACC_W];
      phase_d       = acc_trunc_src[ACC_W-1 -: PHASE_W] + phase_off;
      phase_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      ftw_q         <= '0;
      step_q        <= '0;
      cnt_q         <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      ftw_q         <= ftw_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
    end
  end

  assign ftw_ready   = (state_q != ST_SWEEP);
  assign busy        = (state_q == ST_SWEEP);
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_phase_accum
// Description : Self-checking bench for dds_phase_accum (dither off):
//               directed vector table, wrap/abort/reset sequences and a
//               randomized run against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dds_phase_accum;

  localparam int     ACC_W   = 24;
  localparam int     PHASE_W = 14;
  localparam int     CNT_W   = 16;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam longint PH_MOD  = 64'd1 << PHASE_W;
  localparam int     SHIFT   = ACC_W - PHASE_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic [ACC_W-1:0]   ftw_in;
  logic               ftw_valid;
  logic               ftw_ready;
  logic [PHASE_W-1:0] phase_off;
  logic [ACC_W-1:0]   sweep_step;
  logic [CNT_W-1:0]   sweep_len;
  logic               sweep_start;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;
  logic               busy;

  always #5 clk = ~clk;

  dds_phase_accum #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ftw_in      (ftw_in),
    .ftw_valid   (ftw_valid),
    .ftw_ready   (ftw_ready),
    .phase_off   (phase_off),
    .sweep_step  (sweep_step),
    .sweep_len   (sweep_len),
    .sweep_start (sweep_start),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 sweeping
  int     m_mode;
  int     m_left;
  longint m_acc, m_ftw, m_step, m_phase;
  bit     m_valid, m_wrap;

  task automatic model_reset();
    m_mode = 0; m_left = 0;
    m_acc = 0; m_ftw = 0; m_step = 0; m_phase = 0;
    m_valid = 0; m_wrap = 0;
  endtask

  // Called at each rising edge with the inputs the DUT samples there
  task automatic model_edge();
    bit     running;
    bit     take;
    longint total;
    longint new_ftw;
    running = en && (m_mode != 0);
    take    = ftw_valid && (m_mode != 2);
    new_ftw = m_ftw;
    if (running) begin
      total   = m_acc + m_ftw;
      m_phase = ((m_acc >> SHIFT) + longint'(phase_off)) % PH_MOD;
      m_wrap  = (total >= ACC_MOD);
      m_acc   = total % ACC_MOD;
      m_valid = 1;
    end else begin
      m_wrap  = 0;
      m_valid = 0;
    end
    if (take) new_ftw = longint'(ftw_in);
    if (!en) begin
      m_mode = 0;
      m_left = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (sweep_start && sweep_len != 0) begin
        m_mode = 2;
        m_left = int'(sweep_len);
        m_step = longint'(sweep_step);
      end
    end else begin
      new_ftw = (m_ftw + m_step) % ACC_MOD;
      m_left  = m_left - 1;
      if (m_left == 0) m_mode = 1;
    end
    m_ftw = new_ftw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, " phase"},       32'(phase),       32'(m_phase));
    check({tag, " phase_valid"}, 32'(phase_valid), 32'(m_valid));
    check({tag, " wrap"},        32'(wrap),        32'(m_wrap));
    check({tag, " busy"},        32'(busy),        32'(m_mode == 2));
    check({tag, " ftw_ready"},   32'(ftw_ready),   32'(m_mode != 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic               en;
    logic               fv;
    logic [ACC_W-1:0]   ftw;
    logic [PHASE_W-1:0] off;
    logic               ss;
    logic [ACC_W-1:0]   step;
    logic [CNT_W-1:0]   len;
    logic [PHASE_W-1:0] ph;
    logic               pv;
    logic               wr;
    logic               bz;
    logic               rd;
  } vec_t;

  vec_t vt[14];

  initial begin
    int wrap_cnt;
    int wrap_first;
    int wrap_second;
    logic [PHASE_W-1:0] frozen;
    logic [PHASE_W-1:0] p0;

    rst_n = 1'b0; en = 1'b0; ftw_in = '0; ftw_valid = 1'b0; phase_off = '0;
    sweep_step = '0; sweep_len = '0; sweep_start = 1'b0;
    model_reset();
    #1;
    check("reset phase",       32'(phase),       32'h0);
    check("reset phase_valid", 32'(phase_valid), 32'h0);
    check("reset busy",        32'(busy),        32'h0);
    check("reset ftw_ready",   32'(ftw_ready),   32'h1);
    check("reset wrap",        32'(wrap),        32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //           en fv ftw          off       ss step       len    ph        pv wr bz rd
    vt[0]  = '{1'b0,1'b1,24'h040000,14'h3F80,1'b0,24'h0,    16'd0, 14'h0000,1'b0,1'b0,1'b0,1'b1};
    vt[1]  = '{1'b1,1'b0,24'h000000,14'h3F80,1'b0,24'h0,    16'd0, 14'h0000,1'b0,1'b0,1'b0,1'b1};
    vt[2]  = '{1'b1,1'b0,24'h000000,14'h3F80,1'b0,24'h0,    16'd0, 14'h3F80,1'b1,1'b0,1'b0,1'b1};
    vt[3]  = '{1'b1,1'b0,24'h000000,14'h3F80,1'b0,24'h0,    16'd0, 14'h0080,1'b1,1'b0,1'b0,1'b1};
    vt[4]  = '{1'b1,1'b0,24'h000000,14'h3F80,1'b0,24'h0,    16'd0, 14'h0180,1'b1,1'b0,1'b0,1'b1};
    vt[5]  = '{1'b1,1'b1,24'h001000,14'h0000,1'b0,24'h0,    16'd0, 14'h0300,1'b1,1'b0,1'b0,1'b1};
    vt[6]  = '{1'b1,1'b0,24'h000000,14'h0000,1'b1,24'h10,   16'd4, 14'h0400,1'b1,1'b0,1'b1,1'b0};
    vt[7]  = '{1'b1,1'b1,24'hFFFFFF,14'h0000,1'b0,24'h0,    16'd0, 14'h0404,1'b1,1'b0,1'b1,1'b0};
    vt[8]  = '{1'b1,1'b1,24'hFFFFFF,14'h0000,1'b0,24'h0,    16'd0, 14'h0408,1'b1,1'b0,1'b1,1'b0};
    vt[9]  = '{1'b1,1'b0,24'h000000,14'h0000,1'b0,24'h0,    16'd0, 14'h040C,1'b1,1'b0,1'b1,1'b0};
    vt[10] = '{1'b1,1'b0,24'h000000,14'h0000,1'b0,24'h0,    16'd0, 14'h0410,1'b1,1'b0,1'b0,1'b1};
    vt[11] = '{1'b1,1'b0,24'h000000,14'h0000,1'b0,24'h0,    16'd0, 14'h0414,1'b1,1'b0,1'b0,1'b1};
    vt[12] = '{1'b1,1'b0,24'h000000,14'h0000,1'b0,24'h0,    16'd0, 14'h0418,1'b1,1'b0,1'b0,1'b1};
    vt[13] = '{1'b1,1'b0,24'h000000,14'h0000,1'b0,24'h0,    16'd0, 14'h041C,1'b1,1'b0,1'b0,1'b1};

    for (int i = 0; i < 14; i++) begin
      en = vt[i].en; ftw_valid = vt[i].fv; ftw_in = vt[i].ftw; phase_off = vt[i].off;
      sweep_start = vt[i].ss; sweep_step = vt[i].step; sweep_len = vt[i].len;
      tick();
      check($sformatf("vec%0d phase", i),       32'(phase),       32'(vt[i].ph));
      check($sformatf("vec%0d phase_valid", i), 32'(phase_valid), 32'(vt[i].pv));
      check($sformatf("vec%0d wrap", i),        32'(wrap),        32'(vt[i].wr));
      check($sformatf("vec%0d busy", i),        32'(busy),        32'(vt[i].bz));
      check($sformatf("vec%0d ftw_ready", i),   32'(ftw_ready),   32'(vt[i].rd));
    end
    sweep_start = 1'b0; ftw_valid = 1'b0;

    // ---- wrap period: ftw = 2^24/64 -> carry every 64 updates ----
    do_reset();
    en = 1'b0; ftw_valid = 1'b1; ftw_in = 24'h040000; phase_off = '0;
    tick();
    compare_model("wrapseq load");
    ftw_valid = 1'b0; en = 1'b1;
    wrap_cnt = 0; wrap_first = -1; wrap_second = -1;
    for (int j = 0; j < 140; j++) begin
      tick();
      compare_model("wrapseq");
      if (wrap) begin
        wrap_cnt++;
        if (wrap_first < 0) wrap_first = j;
        else if (wrap_second < 0) wrap_second = j;
      end
    end
    check("wrap first index",  32'(wrap_first),  32'd64);
    check("wrap second index", 32'(wrap_second), 32'd128);
    check("wrap count",        32'(wrap_cnt),    32'd2);

    // ---- abort mid-sweep, then re-enable ----
    ftw_valid = 1'b1; ftw_in = 24'h001000;
    tick();
    ftw_valid = 1'b0;
    sweep_start = 1'b1; sweep_step = 24'h000010; sweep_len = 16'd4;
    tick();
    sweep_start = 1'b0;
    check("abort busy in sweep", 32'(busy), 32'h1);
    tick();
    tick();
    en = 1'b0;
    tick();
    compare_model("abort");
    check("abort busy",        32'(busy),        32'h0);
    check("abort phase_valid", 32'(phase_valid), 32'h0);
    check("abort ftw_ready",   32'(ftw_ready),   32'h1);
    frozen = phase;
    repeat (3) tick();
    check("abort phase frozen", 32'(phase),       32'(frozen));
    check("abort still idle",   32'(phase_valid), 32'h0);
    en = 1'b1;
    tick();
    tick();
    check("reenable valid", 32'(phase_valid), 32'h1);
    p0 = phase;
    repeat (1024) tick();
    // 1024 updates of 0x1020 advance acc by exactly 0x1020 phase LSBs
    check("reenable ftw 0x1020", 32'(PHASE_W'(phase - p0)), 32'h1020);
    compare_model("reenable");

    // ---- asynchronous reset mid-sweep, no clock edge ----
    sweep_start = 1'b1; sweep_len = 16'd100; sweep_step = 24'h1;
    tick();
    sweep_start = 1'b0;
    check("pre-reset busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset phase",       32'(phase),       32'h0);
    check("async reset phase_valid", 32'(phase_valid), 32'h0);
    check("async reset busy",        32'(busy),        32'h0);
    check("async reset ftw_ready",   32'(ftw_ready),   32'h1);
    check("async reset wrap",        32'(wrap),        32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized run against the model ----
    for (int k = 0; k < 4000; k++) begin
      en          = ($urandom_range(0, 39) != 0);
      ftw_valid   = ($urandom_range(0, 7) == 0);
      ftw_in      = ACC_W'($urandom);
      sweep_start = ($urandom_range(0, 11) == 0);
      sweep_len   = CNT_W'($urandom_range(0, 6));
      sweep_step  = ACC_W'($urandom);
      if ($urandom_range(0, 49) == 0) phase_off = PHASE_W'($urandom);
      tick();
      compare_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
